// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and constants for the push-button conditioning logic.
//   btn_state_e          : debounce FSM state (2-bit encoding)
//   BTN_DEBOUNCE_DEFAULT : default stable-cycle count (10 ms at 50 MHz)
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        CHECK_PRESS   = 2'd1,
        PRESSED       = 2'd2,
        CHECK_RELEASE = 2'd3
    } btn_state_e;

    localparam int BTN_DEBOUNCE_DEFAULT = 500000;

endpackage : btn_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Reusable two-flop synchronizer for a single asynchronous input.
// Both flops reset to RESET_VAL so the synchronized value starts out at the
// input's idle level.
// Ports:
//   clk     in  destination clock
//   reset_n in  asynchronous active-low reset
//   d       in  asynchronous input
//   q       out synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule : sync_2ff

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronizes a raw bouncing push-button and debounces it with a saturating
// stability counter. A new level is accepted only after DEBOUNCE_CYCLES+1
// consecutive agreeing samples; any disagreeing sample aborts the check.
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles required to accept a new level (2..2^24)
//   ACTIVE_LOW      : 1 = pin reads 0 when pressed, 0 = pin reads 1 when pressed
//   CNT_W           : counter width, derived from DEBOUNCE_CYCLES
// Ports:
//   clk           in  system clock
//   reset_n       in  asynchronous active-low reset
//   btn_raw       in  raw pad input, asynchronous, may bounce
//   btn_level     out debounced level, 1 = pressed
//   press_pulse   out one-cycle strobe on accepted press
//   release_pulse out one-cycle strobe on accepted release
// -----------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    // Raw value seen while the button is released; also the synchronizer reset
    localparam logic RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_q_s;
    logic             pressed_s;
    btn_state_e       state_r;
    btn_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             level_nxt_s;
    logic             press_nxt_s;
    logic             release_nxt_s;
    logic             level_r;
    logic             press_r;
    logic             release_r;

    sync_2ff #(
        .RESET_VAL(RAW_IDLE)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (btn_raw),
        .q      (sync_q_s)
    );

    // Normalize polarity after synchronization: 1 = pressed
    assign pressed_s = sync_q_s ^ RAW_IDLE;

    // Next-state, counter and output-strobe decode
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        case (state_r)
            RELEASED: begin
                cnt_nxt_s = {CNT_W{1'b0}};
                if (pressed_s) begin
                    state_nxt_s = CHECK_PRESS;
                end else begin
                    state_nxt_s = RELEASED;
                end
            end
            CHECK_PRESS: begin
                if (!pressed_s) begin
                    state_nxt_s = RELEASED;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_MAX) begin
                    state_nxt_s = PRESSED;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    press_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            PRESSED: begin
                cnt_nxt_s = {CNT_W{1'b0}};
                if (!pressed_s) begin
                    state_nxt_s = CHECK_RELEASE;
                end else begin
                    state_nxt_s = PRESSED;
                end
            end
            CHECK_RELEASE: begin
                if (pressed_s) begin
                    state_nxt_s = PRESSED;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_MAX) begin
                    state_nxt_s   = RELEASED;
                    cnt_nxt_s     = {CNT_W{1'b0}};
                    release_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s     = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = RELEASED;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
        // Level follows the accepted state; CHECK_RELEASE is still "pressed"
        level_nxt_s = (state_nxt_s == PRESSED) || (state_nxt_s == CHECK_RELEASE);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= RELEASED;
            cnt_r     <= {CNT_W{1'b0}};
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            level_r   <= level_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
        end
    end

    assign btn_level     = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
// Self-checking bench for btn_debounce with DEBOUNCE_CYCLES=8. Two instances
// run side by side: one active-low pin, one active-high pin, both driven from
// the same logical "pressed" stimulus. A run-length reference model predicts
// every output every cycle.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int D = 8;

    logic clk;
    logic reset_n;
    logic pressed;
    logic raw_lo;
    logic raw_hi;
    logic level_lo, press_lo, release_lo;
    logic level_hi, press_hi, release_hi;

    int n_checks;
    int n_errors;

    // Reference model state, index 0 = active-low pin, 1 = active-high pin
    logic m_sync1 [2];
    logic m_sync2 [2];
    int   m_run   [2];
    logic m_level [2];
    logic m_press [2];
    logic m_rel   [2];

    assign raw_lo = ~pressed;
    assign raw_hi = pressed;

    btn_debounce #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)) dut_lo (
        .clk(clk), .reset_n(reset_n), .btn_raw(raw_lo),
        .btn_level(level_lo), .press_pulse(press_lo), .release_pulse(release_lo)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0)) dut_hi (
        .clk(clk), .reset_n(reset_n), .btn_raw(raw_hi),
        .btn_level(level_hi), .press_pulse(press_hi), .release_pulse(release_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Level is accepted once the synchronized value has disagreed with it for
    // D+1 consecutive samples; any agreeing sample restarts the count.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic idle;
            logic s;
            idle = (k == 0) ? 1'b1 : 1'b0;
            m_press[k] = 1'b0;
            m_rel[k]   = 1'b0;
            if (!reset_n) begin
                m_sync1[k] = idle;
                m_sync2[k] = idle;
                m_run[k]   = 0;
                m_level[k] = 1'b0;
            end else begin
                s = m_sync2[k] ^ idle;
                if (s != m_level[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D + 1) begin
                        m_level[k] = s;
                        m_run[k]   = 0;
                        if (s) m_press[k] = 1'b1;
                        else   m_rel[k]   = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_sync2[k] = m_sync1[k];
                m_sync1[k] = (k == 0) ? raw_lo : raw_hi;
            end
        end
    endtask

    // One clock: update model at the edge, compare all outputs 1 ns later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_value("lo_level",   {31'd0, level_lo},   {31'd0, m_level[0]});
        check_value("lo_press",   {31'd0, press_lo},   {31'd0, m_press[0]});
        check_value("lo_release", {31'd0, release_lo}, {31'd0, m_rel[0]});
        check_value("hi_level",   {31'd0, level_hi},   {31'd0, m_level[1]});
        check_value("hi_press",   {31'd0, press_hi},   {31'd0, m_press[1]});
        check_value("hi_release", {31'd0, release_hi}, {31'd0, m_rel[1]});
    endtask

    // Steps until the chosen pulse is seen on both instances; returns edges
    // after the first capture edge (-1 if never seen within the budget).
    task automatic measure(input logic want_press, output int lat_lo, output int lat_hi,
                           output int cnt_lo, output int cnt_hi);
        lat_lo = -1; lat_hi = -1; cnt_lo = 0; cnt_hi = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (want_press ? press_lo : release_lo) begin
                cnt_lo++;
                if (lat_lo < 0) lat_lo = i;
            end
            if (want_press ? press_hi : release_hi) begin
                cnt_hi++;
                if (lat_hi < 0) lat_hi = i;
            end
        end
    endtask

    initial begin
        int ll, lh, cl, ch;
        int pulses;
        n_checks = 0;
        n_errors = 0;
        pressed  = 1'b0;
        reset_n  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_sync1[k] = (k == 0); m_sync2[k] = (k == 0);
            m_run[k] = 0; m_level[k] = 1'b0; m_press[k] = 1'b0; m_rel[k] = 1'b0;
        end

        // Reset held with pin idle: everything low
        repeat (5) step();
        check_value("rst_outputs", {26'd0, level_lo, press_lo, release_lo, level_hi, press_hi, release_hi}, 32'd0);
        reset_n = 1'b1;
        repeat (50) step();
        check_value("idle_level", {31'd0, level_lo}, 32'd0);

        // Clean press
        pressed = 1'b1;
        measure(1'b1, ll, lh, cl, ch);
        check_value("press_lat_lo", ll, D + 2);
        check_value("press_lat_hi", lh, D + 2);
        check_value("press_cnt_lo", cl, 1);
        check_value("press_cnt_hi", ch, 1);
        check_value("press_level",  {31'd0, level_lo}, 32'd1);

        // Clean release
        pressed = 1'b0;
        measure(1'b0, ll, lh, cl, ch);
        check_value("rel_lat_lo", ll, D + 2);
        check_value("rel_lat_hi", lh, D + 2);
        check_value("rel_cnt_lo", cl, 1);
        check_value("rel_level",  {31'd0, level_lo}, 32'd0);

        // Bounce runs of 3, 5, 7: no pulses
        pulses = 0;
        for (int r = 3; r <= 7; r += 2) begin
            pressed = 1'b1;
            for (int i = 0; i < r; i++) begin step(); pulses += press_lo + release_lo + press_hi + release_hi; end
            pressed = 1'b0;
            for (int i = 0; i < r; i++) begin step(); pulses += press_lo + release_lo + press_hi + release_hi; end
        end
        check_value("bounce_pulses", pulses, 0);
        check_value("bounce_level",  {31'd0, level_lo}, 32'd0);
        pressed = 1'b1;
        measure(1'b1, ll, lh, cl, ch);
        check_value("bounce_press_lat", ll, D + 2);

        // Release, then interrupt a press check at cnt=5 with reset
        pressed = 1'b0;
        repeat (20) step();
        pressed = 1'b1;
        repeat (8) step();
        reset_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin step(); pulses += press_lo + press_hi; end
        check_value("midrst_pulses", pulses, 0);
        reset_n = 1'b1;
        measure(1'b1, ll, lh, cl, ch);
        check_value("midrst_lat_lo", ll, D + 2);
        check_value("midrst_lat_hi", lh, D + 2);
        check_value("midrst_cnt",    cl, 1);

        // Randomized runs with occasional resets, checked by the model
        for (int it = 0; it < 300; it++) begin
            int len;
            len = int'($urandom_range(1, 14));
            pressed = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) reset_n = 1'b0;
            for (int i = 0; i < len; i++) begin
                step();
                reset_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_btn_debounce

// File: doc/btn_debounce.md
# btn_debounce

Button conditioning stage sitting directly upstream of the Nios button PIO. It takes a raw, asynchronous, bouncing push-button input, synchronizes it into `clk`, and debounces it with a saturating stability counter. It outputs a clean active-high level that drives the PIO `in_port`. It also produces single-cycle press/release pulses for the pong paddle logic.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 2..2^24.
- `ACTIVE_LOW`, 1: 1 = raw pin reads 0 when pressed (DE-board KEY); 0 = raw pin reads 1 when pressed.
- `CNT_W`, $clog2(DEBOUNCE_CYCLES): counter width; derived, not overridden.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset reset_n, asynchronous, active-low; clock clk.
- `btn_raw`  in  1  raw pad input, asynchronous to `clk`, may bounce.
- `btn_level`  out  1  debounced level, 1 = pressed; feeds PIO `in_port`.
- `press_pulse`  out  1  one-cycle strobe on accepted released->pressed transition.
- `release_pulse`  out  1  one-cycle strobe on accepted pressed->released transition.

## Operation
- Synchronizer: 2 flops on `btn_raw`; both reset to the *released* raw value (1 if `ACTIVE_LOW`, else 0). Polarity is normalized after the synchronizer: `s = sync_q ^ ACTIVE_LOW` (1 = pressed).
- FSM states:
  - RELEASED: `btn_level`=0. If `s`=1 -> CHECK_PRESS with cnt=0.
  - CHECK_PRESS: if `s`=0 -> RELEASED, cnt=0. Else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED, assert `press_pulse`. Else cnt++.
  - PRESSED: `btn_level`=1. If `s`=0 -> CHECK_RELEASE with cnt=0.
  - CHECK_RELEASE: if `s`=1 -> PRESSED, cnt=0. Else if cnt==DEBOUNCE_CYCLES-1 -> RELEASED, assert `release_pulse`. Else cnt++.
- A bounce during a CHECK state aborts the check and returns to the prior stable state. No pulse is produced and the counter clears. The next opposite sample restarts the check from 0.
- Counter never wraps. It is compared and cleared, never incremented past DEBOUNCE_CYCLES-1.
- `btn_level`, `press_pulse` and `release_pulse` are registered outputs. Pulses are mutually exclusive and never assert in consecutive cycles.
- Reset: state=RELEASED, cnt=0, all outputs 0. A button held through reset deassertion is accepted as a press only after the full debounce period, then yields one `press_pulse`.
- Reset mid-check: state and counter return to RELEASED/0 immediately. No pulse is emitted for the interrupted check.

## Timing
- Latency: `btn_raw` becomes stable and is first captured at edge E0. The synchronizer output changes at E1. `btn_level` and the pulse assert on edge E1+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges after E0.
- Minimum accepted press width: DEBOUNCE_CYCLES+1 stable cycles at the synchronizer output. A glitch of N<DEBOUNCE_CYCLES+1 cycles has no effect on any output.
- Each pulse is high for exactly 1 cycle, coincident with the `btn_level` change.
- The PIO samples `btn_level` one cycle later, so the end-to-end debounce-to-readdata path adds 1 cycle.

## Structure
- Package `btn_pkg` holds:
  - the state enum (RELEASED, CHECK_PRESS, PRESSED, CHECK_RELEASE; 2-bit encoding);
  - the default constant `BTN_DEBOUNCE_DEFAULT` = 500000.
- Sub-module `sync_2ff` (parameter `RESET_VAL`): a reusable 2-flop synchronizer with async active-low reset. It is instanced once here and also used for other board inputs.
- The remaining logic is a single FSM + counter always block plus registered output decode.

## Test plan
Benches use `DEBOUNCE_CYCLES`=8 and `ACTIVE_LOW`=1.
- Reset: hold `reset_n`=0 with `btn_raw`=1 -> all outputs 0; after release, outputs stay 0 for 50 cycles.
- Clean press: drop `btn_raw` to 0 at edge 10 and hold -> `btn_level`=1 and `press_pulse`=1 at edge 20 only; `btn_level` stays 1.
- Bounce rejection: toggle `btn_raw` 0/1 with runs of 3, 5 and 7 cycles -> no pulses, `btn_level` stays 0. Then hold 0 -> `press_pulse` 10 edges after the final falling edge.
- Release: from PRESSED, raise `btn_raw` to 1 and hold -> `btn_level`=0 and a single `release_pulse` 10 edges later.
- Reset mid-check: assert `reset_n`=0 at cnt=5 during CHECK_PRESS, hold `btn_raw`=0 through reset -> no pulse during reset; `press_pulse` exactly 10 edges after reset deassertion.
- `ACTIVE_LOW`=0 variant: raise `btn_raw` to 1 and hold -> `press_pulse` after 10 edges; polarity of all outputs unchanged.
